// File: rtl/acq_frame_scheduler.sv
// acq_frame_scheduler: frame-paced ADC capture shipped as UART byte packets; ACQ_CHECKSUM_EN appends an XOR checksum byte
module acq_frame_scheduler #(
  parameter int          FRAME_PERIOD = 50000,
  parameter int          TIMEOUT_CYC  = 4096,
  parameter logic [7:0]  HDR_BYTE     = 8'hA5
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        start_n,
  input  logic        stop_req,
  input  logic [7:0]  frames_cfg,
  output logic        adc_start_n,
  input  logic        adc_cs_n,
  input  logic [15:0] adc_data,
  output logic        tx_launch_n,
  input  logic        tx_done,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [7:0]  frame_idx,
  output logic        err_timeout,
  output logic        err_overrun
);
  localparam int PW = $clog2(FRAME_PERIOD);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [PW-1:0] P_LOAD = PW'(FRAME_PERIOD - 1);
  localparam logic [TW-1:0] T_LIM  = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0] IDLE      = 4'd0;
  localparam logic [3:0] ARM       = 4'd1;
  localparam logic [3:0] CONV      = 4'd2;
  localparam logic [3:0] WAIT_LOW  = 4'd3;
  localparam logic [3:0] WAIT_HIGH = 4'd4;
  localparam logic [3:0] TX_HDR    = 4'd5;
  localparam logic [3:0] TX_HI     = 4'd6;
  localparam logic [3:0] TX_LO     = 4'd7;
  localparam logic [3:0] TX_GAP    = 4'd9;
  localparam logic [3:0] NEXT      = 4'd10;
`ifdef ACQ_CHECKSUM_EN
  localparam logic [3:0] TX_CHK    = 4'd8;
  localparam logic [3:0] LAST_TX   = TX_CHK;
`else
  localparam logic [3:0] LAST_TX   = TX_LO;
`endif
  logic [3:0]    st, gap_to;
  logic [2:0]    start_sync;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] phase_cnt;
  logic [7:0]    frames_left;
  logic [15:0]   sample_q;
  logic          cont, stop_pend, late, start_edge, timed_out, tx_st;
  assign start_edge  = start_sync[2] & ~start_sync[1];
  assign timed_out   = phase_cnt == T_LIM;
  assign tx_st       = st inside {[TX_HDR:LAST_TX]};
  assign adc_start_n = st != CONV;
  assign tx_launch_n = !tx_st;
  always_comb begin
    tx_data = st == TX_HDR ? HDR_BYTE :
              st == TX_HI  ? sample_q[15:8] :
              st == TX_LO  ? sample_q[7:0] : 8'h00;
`ifdef ACQ_CHECKSUM_EN
    if (st == TX_CHK) tx_data = HDR_BYTE ^ sample_q[15:8] ^ sample_q[7:0];
`endif
  end
  // TX byte states are contiguous, so the byte after st is st+1 until LAST_TX
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      start_sync  <= '1;
      st          <= IDLE;
      gap_to      <= IDLE;
      period_cnt  <= '0;
      phase_cnt   <= '0;
      frames_left <= '0;
      sample_q    <= '0;
      cont        <= 1'b0;
      stop_pend   <= 1'b0;
      late        <= 1'b0;
      busy        <= 1'b0;
      frame_idx   <= '0;
      err_timeout <= 1'b0;
      err_overrun <= 1'b0;
    end else begin
      start_sync <= {start_sync[1:0], start_n};
      phase_cnt  <= phase_cnt + TW'(1);
      if (busy && period_cnt != '0) period_cnt <= period_cnt - PW'(1);
      if (busy && stop_req) stop_pend <= 1'b1;
      case (st)
        IDLE: if (start_edge) begin
          st          <= ARM;
          busy        <= 1'b1;
          frame_idx   <= '0;
          frames_left <= frames_cfg;
          cont        <= frames_cfg == '0;
          stop_pend   <= 1'b0;
          err_timeout <= 1'b0;
          err_overrun <= 1'b0;
        end
        ARM: begin
          period_cnt <= P_LOAD;
          st         <= CONV;
        end
        CONV: begin
          phase_cnt <= '0;
          st        <= WAIT_LOW;
        end
        WAIT_LOW: if (!adc_cs_n) begin
          phase_cnt <= '0;
          st        <= WAIT_HIGH;
        end else if (timed_out) begin
          err_timeout <= 1'b1;
          busy        <= 1'b0;
          st          <= IDLE;
        end
        WAIT_HIGH: if (adc_cs_n) begin
          sample_q <= adc_data;
          st       <= TX_HDR;
        end else if (timed_out) begin
          err_timeout <= 1'b1;
          busy        <= 1'b0;
          st          <= IDLE;
        end
        TX_GAP: if (!tx_done) begin
          st <= gap_to;
          if (gap_to == NEXT) begin
            frame_idx <= frame_idx + 8'd1;
            late      <= period_cnt == '0;
            if (!cont) frames_left <= frames_left - 8'd1;
          end
        end
        NEXT: if (stop_pend || stop_req || (!cont && frames_left == '0)) begin
          busy <= 1'b0;
          st   <= IDLE;
        end else if (period_cnt == '0) begin
          period_cnt  <= P_LOAD;
          err_overrun <= err_overrun | late;
          st          <= CONV;
        end
        default: if (tx_st) begin
          if (tx_done) begin
            gap_to <= st == LAST_TX ? NEXT : st + 4'd1;
            st     <= TX_GAP;
          end
        end else st <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acq_frame_scheduler.sv
// tb_acq_frame_scheduler: randomized ADC/UART models checked against a packet and frame-timing reference
module tb_acq_frame_scheduler;
  localparam int P = 2000;
  localparam int T = 4096;
`ifdef ACQ_CHECKSUM_EN
  localparam int BPF = 4;
`else
  localparam int BPF = 3;
`endif
  logic        clk_in = 1'b0, reset = 1'b0, start_n = 1'b1, stop_req = 1'b0;
  logic        adc_cs_n = 1'b1, tx_done = 1'b0;
  logic [7:0]  frames_cfg = 8'd0;
  logic [15:0] adc_data = 16'd0;
  logic        adc_start_n, tx_launch_n, busy, err_timeout, err_overrun;
  logic [7:0]  tx_data, frame_idx;
  int n_checks = 0, n_errs = 0, cyc = 0;
  int uart_dly = 2, cs_dly = 3, cs_hold = 40;
  bit adc_mute = 1'b0, force_en = 1'b0;
  logic [15:0] force_val = 16'd0, a_val;
  logic [7:0]  rx_q[$];
  logic [15:0] samp_q[$];
  int conv_q[$], drop_q[$];
  int busy_fall = -1, tout_rise = -1, wide_pulse = 0, bad_stable = 0, launch_cnt = 0;
  int u_cnt = 0;
  logic [7:0] u_cur = 8'd0;
  logic prev_sn = 1'b1, prev_busy = 1'b0, prev_to = 1'b0;

  acq_frame_scheduler #(.FRAME_PERIOD(P), .TIMEOUT_CYC(T), .HDR_BYTE(8'hA5)) dut (
    .clk_in(clk_in), .reset(reset), .start_n(start_n), .stop_req(stop_req),
    .frames_cfg(frames_cfg), .adc_start_n(adc_start_n), .adc_cs_n(adc_cs_n),
    .adc_data(adc_data), .tx_launch_n(tx_launch_n), .tx_done(tx_done),
    .tx_data(tx_data), .busy(busy), .frame_idx(frame_idx),
    .err_timeout(err_timeout), .err_overrun(err_overrun));

  initial forever #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ADC driver: cs_n low cs_dly cycles after the start pulse, data valid on the rising cs_n
  initial forever begin
    @(negedge clk_in);
    if (!adc_start_n && !adc_mute) begin
      repeat (cs_dly) @(negedge clk_in);
      a_val = force_en ? force_val : 16'($urandom);
      adc_cs_n = 1'b0;
      adc_data = ~a_val;
      repeat (cs_hold) @(negedge clk_in);
      adc_data = a_val;
      adc_cs_n = 1'b1;
      samp_q.push_back(a_val);
    end
  end

  // UART: done after uart_dly launch cycles, held until launch releases
  initial forever begin
    @(negedge clk_in);
    if (!reset) begin
      tx_done = 1'b0;
      u_cnt = 0;
    end else if (tx_done) begin
      if (tx_launch_n) begin
        tx_done = 1'b0;
        u_cnt = 0;
        drop_q.push_back(cyc);
      end
    end else if (!tx_launch_n) begin
      if (u_cnt == 0) begin
        rx_q.push_back(tx_data);
        u_cur = tx_data;
      end else if (tx_data !== u_cur) bad_stable++;
      u_cnt++;
      if (u_cnt >= uart_dly) tx_done = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk_in);
    if (!adc_start_n) begin
      if (prev_sn) conv_q.push_back(cyc);
      else wide_pulse++;
    end
    if (prev_busy && !busy) busy_fall = cyc;
    if (!prev_to && err_timeout) tout_rise = cyc;
    if (!tx_launch_n) launch_cnt++;
    prev_sn = adc_start_n;
    prev_busy = busy;
    prev_to = err_timeout;
  end

  task automatic clear_logs();
    rx_q.delete(); samp_q.delete(); conv_q.delete(); drop_q.delete();
    busy_fall = -1; tout_rise = -1; wide_pulse = 0; bad_stable = 0; launch_cnt = 0;
  endtask

  task automatic press(input bit hold);
    @(negedge clk_in) start_n = 1'b0;
    repeat (4) @(negedge clk_in);
    if (!hold) start_n = 1'b1;
    check("busy_rise", busy, 1);
    check("first_frame_idx", frame_idx, 0);
  endtask

  task automatic wait_idle(input int budget);
    int t = 0;
    while (busy && t < budget) begin
      @(negedge clk_in);
      t++;
    end
    check("run_ends", busy, 0);
  endtask

  task automatic check_bytes(input int n);
    logic [7:0] exp_b[$];
    logic [15:0] s;
    foreach (samp_q[i]) begin
      s = samp_q[i];
      exp_b.push_back(8'hA5);
      exp_b.push_back(s[15:8]);
      exp_b.push_back(s[7:0]);
`ifdef ACQ_CHECKSUM_EN
      exp_b.push_back(8'hA5 ^ s[15:8] ^ s[7:0]);
`endif
    end
    check("samples", samp_q.size(), n);
    check("byte_count", rx_q.size(), BPF * n);
    for (int i = 0; i < rx_q.size() && i < exp_b.size(); i++)
      check($sformatf("byte%0d", i), rx_q[i], exp_b[i]);
  endtask

  // late frames restart two cycles after the final tx_done release, others exactly P apart
  task automatic check_timing(input int n, input bit ovr);
    check("conv_count", conv_q.size(), n);
    for (int f = 1; f < conv_q.size(); f++)
      if (ovr) check("conv_after_next", conv_q[f], drop_q[BPF * f - 1] + 2);
      else check("conv_gap", conv_q[f] - conv_q[f - 1], P);
    check("busy_fall", busy_fall, drop_q[drop_q.size() - 1] + 2);
    check("overrun", err_overrun, ovr);
    check("timeout_flag", err_timeout, 0);
    check("pulse_width", wide_pulse, 0);
    check("tx_stable", bad_stable, 0);
    check("frame_idx", frame_idx, n);
  endtask

  task automatic run_frames(input int n);
    bit ovr;
    clear_logs();
    frames_cfg = 8'(n);
    press(1'b0);
    wait_idle(n * 6000 + 2000);
    ovr = n > 1 && (BPF * uart_dly + cs_dly + cs_hold > P);
    check_bytes(n);
    check_timing(n, ovr);
  endtask

  initial begin
    int t;
    repeat (3) @(negedge clk_in);
    check("rst_adc_start_n", adc_start_n, 1);
    check("rst_tx_launch_n", tx_launch_n, 1);
    check("rst_tx_data", tx_data, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_idx", frame_idx, 0);
    check("rst_errs", {err_timeout, err_overrun}, 0);
    reset = 1'b1;
    repeat (3) @(negedge clk_in);
    force_en = 1'b1; force_val = 16'h0ABC;
    run_frames(1);
    force_en = 1'b0;
    uart_dly = 4;
    run_frames(3);
    uart_dly = 800;
    run_frames(3);
    uart_dly = 3;
    clear_logs();
    adc_mute = 1'b1;
    frames_cfg = 8'd1;
    press(1'b0);
    wait_idle(T + 1000);
    check("to_convs", conv_q.size(), 1);
    check("to_rise", tout_rise, conv_q[0] + 1 + T);
    check("to_flag", err_timeout, 1);
    check("to_launch", launch_cnt, 0);
    adc_mute = 1'b0;
    clear_logs();
    uart_dly = 5;
    frames_cfg = 8'd0;
    press(1'b1);
    t = 0;
    while (rx_q.size() < 2 * BPF + 2 && t < 10000) begin
      @(negedge clk_in);
      t++;
    end
    stop_req = 1'b1;
    @(negedge clk_in) stop_req = 1'b0;
    wait_idle(6000);
    check_bytes(3);
    check_timing(3, 1'b0);
    repeat (100) @(negedge clk_in);
    check("held_no_restart", busy, 0);
    check("held_no_conv", conv_q.size(), 3);
    start_n = 1'b1;
    clear_logs();
    frames_cfg = 8'd2;
    press(1'b0);
    t = 0;
    while (tx_launch_n && t < 5000) begin
      @(negedge clk_in);
      t++;
    end
    check("reached_hdr", tx_data, 8'hA5);
    #1 reset = 1'b0;
    #1;
    check("arst_launch", tx_launch_n, 1);
    check("arst_start", adc_start_n, 1);
    check("arst_busy", busy, 0);
    check("arst_frame_idx", frame_idx, 0);
    repeat (3) @(negedge clk_in);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    run_frames(1);
    for (int r = 0; r < 3; r++) begin
      uart_dly = $urandom_range(1, 20);
      cs_dly = $urandom_range(1, 6);
      cs_hold = $urandom_range(1, 60);
      run_frames($urandom_range(1, 3));
    end
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end
endmodule

// File: doc/acq_frame_scheduler.md
Name: acq_frame_scheduler

Overview:
- Sequences repeated single-pixel acquisitions: triggers the ADC128S022 driver once per frame, captures the 16-bit result, and ships it to the UART_Tx block as a framed byte packet.
- Sits between the top-level pixel FSM / start button and the ADC and UART blocks.
- Owns frame timing, the frame count, ADC/UART handshakes, and timeout/overrun error reporting.

Parameters:
- FRAME_PERIOD, 50000: clk_in cycles between successive conversion starts (minimum 64).
- TIMEOUT_CYC, 4096: maximum cycles allowed for each ADC handshake phase.
- HDR_BYTE, 8'hA5: first byte of every packet.

Ports:
- clk_in  input  1  system clock, 50 MHz.
- reset  input  1  asynchronous, active-low.
- start_n  input  1  asynchronous start request, active-low, level from button.
- stop_req  input  1  synchronous; request graceful stop.
- frames_cfg  input  8  frames per run; 0 = continuous until stop_req.
- adc_start_n  output  1  to driver start_convert, active-low.
- adc_cs_n  input  1  driver ADC_CS_N; low = conversion in progress.
- adc_data  input  16  driver data_out; valid when adc_cs_n returns high.
- tx_launch_n  output  1  to UART TX_LAUNCH, active-low.
- tx_done  input  1  UART transmit_flg; high = byte finished.
- tx_data  output  8  byte presented to UART.
- busy  output  1  high while a run is active.
- frame_idx  output  8  index of the current frame, 0-based.
- err_timeout  output  1  sticky; ADC handshake timeout.
- err_overrun  output  1  sticky; packet outlasted FRAME_PERIOD.

Behaviour:
- Reset values (async, while reset low):
  - adc_start_n=1, tx_launch_n=1, tx_data=0, busy=0, frame_idx=0, err_* = 0.
  - FSM returns to IDLE; all counters = 0.
- start_n passes through a 2-flop synchronizer. A run starts on a synchronized falling edge, so a held button gives one run only.
- States: IDLE, ARM, CONV, WAIT_LOW, WAIT_HIGH, TX_HDR, TX_HI, TX_LO, TX_GAP, NEXT.
- IDLE:
  - On a start edge, clear err_*, frame_idx=0, latch frames_cfg into frames_left, busy=1, go to ARM.
- ARM:
  - Period counter is loaded with FRAME_PERIOD-1. Next cycle go to CONV.
- Period counter:
  - Decrements every cycle while busy and saturates at 0.
  - The "period elapsed" condition is counter==0.
- CONV:
  - adc_start_n=0 for exactly 1 cycle, then go to WAIT_LOW.
- WAIT_LOW:
  - Wait for adc_cs_n==0, then go to WAIT_HIGH.
- WAIT_HIGH:
  - Wait for adc_cs_n==1. On that cycle register adc_data into sample_q and go to TX_HDR.
- Timeouts:
  - A phase counter is cleared on entry to WAIT_LOW and to WAIT_HIGH.
  - If it reaches TIMEOUT_CYC, set err_timeout=1, busy=0, adc_start_n=1, and go to IDLE.
- TX_HDR / TX_HI / TX_LO:
  - tx_data = HDR_BYTE, then sample_q[15:8], then sample_q[7:0].
  - tx_launch_n=0 held until tx_done==1 is sampled; then tx_launch_n=1 and go to TX_GAP.
  - tx_data is stable for the whole state.
- TX_GAP:
  - tx_launch_n=1 for at least 1 cycle and until tx_done==0, then advance to the next byte.
  - After the last byte, go to NEXT.
- NEXT:
  - frame_idx increments with 8-bit wrap.
  - If frames_cfg≠0, frames_left decrements. Run ends when frames_left reaches 0, or when stop_req was seen.
  - At run end: busy=0, go to IDLE.
  - Otherwise wait for period elapsed, reload the period counter, and go to CONV.
  - If the period had already elapsed on entry to NEXT, set err_overrun=1 and start the next frame immediately.
- stop_req is latched (stop_pend) in any busy state. The current packet always completes; no new CONV is issued after it.
- A start edge while busy is ignored.
- Reset mid-packet aborts immediately. No partial-packet recovery.

Optional Feature:
- Macro ACQ_CHECKSUM_EN.
- When defined:
  - Add state TX_CHK after TX_LO.
  - It sends HDR_BYTE ^ sample_q[15:8] ^ sample_q[7:0] with the same launch/gap handshake. Packet = 4 bytes.
- When undefined:
  - Packet = 3 bytes; TX_CHK and its logic are absent.

Test Plan:
1. Single frame:
   - Stimulus: frames_cfg=1, pulse start_n low. ADC model pulls cs_n low 3 cycles after adc_start_n, holds it 40 cycles, data=16'h0ABC.
   - Required: one adc_start_n pulse 1 cycle wide; bytes A5, 0A, BC; busy drops after the last tx_done; frame_idx=1.
2. Frame pacing:
   - Stimulus: frames_cfg=3, FRAME_PERIOD=2000, fast UART model.
   - Required: adc_start_n falling edges exactly 2000 cycles apart; 9 bytes total; err_overrun=0.
3. Overrun:
   - Stimulus: FRAME_PERIOD=64, UART model takes 100 cycles per byte.
   - Required: err_overrun=1 after frame 0; next CONV in the cycle after NEXT; all packets complete.
4. Timeout:
   - Stimulus: ADC model never pulls cs_n low, TIMEOUT_CYC=4096.
   - Required: err_timeout=1 at 4096 cycles after WAIT_LOW entry; busy=0; tx_launch_n never asserted.
5. Stop and held start:
   - Stimulus: frames_cfg=0, assert stop_req mid-TX_HI of frame 2; hold start_n low throughout.
   - Required: frame 2 packet completes; no further CONV; busy=0; no restart from the held button.
6. Reset mid-run:
   - Stimulus: reset low during TX_HDR.
   - Required: tx_launch_n=1, adc_start_n=1, busy=0 immediately (async); a new start after release begins at frame_idx=0.
